// File: rtl/v_ist_scoreboard_if.sv
// ----------------------------------------------------------------------------
// v_ist_scoreboard_if
// Bundles the decode-side issue port, the FU stage-update port, the retire
// report and the occupancy status of the vector instruction status table.
//   issue_*  : decode -> table. An instruction is accepted on a rising edge
//              where issue_valid && issue_ready. issue_ready is combinational
//              and does not depend on issue_valid; decode may hold
//              issue_valid high and must keep the fields stable until accept.
//   upd_*    : FU -> table, single-cycle strobe, no back-pressure.
//   retire_* : table -> outside, retire_valid is a one-cycle pulse.
//   count/full/empty : occupancy of the table.
// Modports: slave = the scoreboard itself, master = decode/FU side.
// ----------------------------------------------------------------------------
interface v_ist_scoreboard_if #(
  parameter int NO_OF_SLOTS = 8,
  parameter int OP_BITS     = 6,
  parameter int NUM_VREGS   = 32
);
  localparam int RW    = $clog2(NUM_VREGS);
  localparam int TAG_W = $clog2(NO_OF_SLOTS);

  logic               issue_valid;
  logic [OP_BITS-1:0] issue_op;
  logic [RW-1:0]      issue_vd;
  logic [RW-1:0]      issue_vs1;
  logic [RW-1:0]      issue_vs2;
  logic               issue_ready;
  logic [TAG_W-1:0]   issue_tag;
  logic               hazard;

  logic               upd_valid;
  logic [TAG_W-1:0]   upd_tag;
  logic [2:0]         upd_stage;

  logic               retire_valid;
  logic [OP_BITS-1:0] retire_op;
  logic [RW-1:0]      retire_vd;

  logic [TAG_W:0]     count;
  logic               full;
  logic               empty;

  modport slave (
    input  issue_valid, issue_op, issue_vd, issue_vs1, issue_vs2,
    input  upd_valid, upd_tag, upd_stage,
    output issue_ready, issue_tag, hazard,
    output retire_valid, retire_op, retire_vd,
    output count, full, empty
  );

  modport master (
    output issue_valid, issue_op, issue_vd, issue_vs1, issue_vs2,
    output upd_valid, upd_tag, upd_stage,
    input  issue_ready, issue_tag, hazard,
    input  retire_valid, retire_op, retire_vd,
    input  count, full, empty
  );
endinterface

// File: rtl/v_ist_scoreboard.sv
// ----------------------------------------------------------------------------
// v_ist_scoreboard
// In-order instruction status table plus per-vreg busy scoreboard for the
// vector coprocessor. Issued instructions go into a circular table at the
// tail; FUs move each entry through IS(0)/RO(1)/EX(2)/WB(3)/DONE(4) by tag;
// the head entry retires once it reaches DONE and is reported for one cycle.
// A vreg stays busy from accept of its writer until that writer retires, so
// any issue touching a busy vreg (RAW or WAW) is stalled.
// Ports:
//   clk  - clock, all state on the rising edge
//   nrst - synchronous active-low reset, drops every entry
//   sb   - v_ist_scoreboard_if.slave (issue, update, retire, status)
// ----------------------------------------------------------------------------
module v_ist_scoreboard #(
  parameter int NO_OF_SLOTS = 8,
  parameter int OP_BITS     = 6,
  parameter int NUM_VREGS   = 32
) (
  input  logic                  clk,
  input  logic                  nrst,
  v_ist_scoreboard_if.slave     sb
);
  localparam int RW    = $clog2(NUM_VREGS);
  localparam int TAG_W = $clog2(NO_OF_SLOTS);

  localparam logic [2:0]     ST_IS    = 3'd0;
  localparam logic [2:0]     ST_DONE  = 3'd4;
  localparam logic [TAG_W:0] SLOTS    = (TAG_W+1)'(NO_OF_SLOTS);
  localparam logic [TAG_W:0] CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  // Table storage
  logic [NO_OF_SLOTS-1:0] valid_q, valid_d;
  logic [OP_BITS-1:0]     op_q    [NO_OF_SLOTS];
  logic [OP_BITS-1:0]     op_d    [NO_OF_SLOTS];
  logic [RW-1:0]          vd_q    [NO_OF_SLOTS];
  logic [RW-1:0]          vd_d    [NO_OF_SLOTS];
  logic [2:0]             stage_q [NO_OF_SLOTS];
  logic [2:0]             stage_d [NO_OF_SLOTS];

  logic [TAG_W-1:0]       head_q, head_d;
  logic [TAG_W-1:0]       tail_q, tail_d;
  logic [TAG_W:0]         count_q, count_d;
  logic [NUM_VREGS-1:0]   busy_q, busy_d;

  logic                   retire_valid_q, retire_valid_d;
  logic [OP_BITS-1:0]     retire_op_q, retire_op_d;
  logic [RW-1:0]          retire_vd_q, retire_vd_d;

  logic hazard;
  logic full;
  logic accept;
  logic retire_fire;
  logic vd_shared;

  // Hazard and readiness come only from registered state, so a retire in
  // the same cycle never frees a vreg for an issue in that cycle.
  always_comb begin
    hazard = busy_q[sb.issue_vd] | busy_q[sb.issue_vs1] | busy_q[sb.issue_vs2];
    full   = (count_q == SLOTS);
    accept = sb.issue_valid && !full && !hazard;
    retire_fire = valid_q[head_q] && (stage_q[head_q] == ST_DONE);
  end

  // Another live entry writing the same vreg keeps the busy bit set.
  always_comb begin
    vd_shared = 1'b0;
    for (int i = 0; i < NO_OF_SLOTS; i++) begin
      if ((TAG_W'(i) != head_q) && valid_q[i] && (vd_q[i] == vd_q[head_q])) begin
        vd_shared = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d        = valid_q;
    op_d           = op_q;
    vd_d           = vd_q;
    stage_d        = stage_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    busy_d         = busy_q;
    retire_valid_d = 1'b0;
    retire_op_d    = retire_op_q;
    retire_vd_d    = retire_vd_q;

    // Stage updates only move forward, only on live slots, only to legal codes.
    if (sb.upd_valid && valid_q[sb.upd_tag] &&
        (sb.upd_stage > stage_q[sb.upd_tag]) && (sb.upd_stage <= ST_DONE)) begin
      stage_d[sb.upd_tag] = sb.upd_stage;
    end

    if (retire_fire) begin
      valid_d[head_q] = 1'b0;
      retire_valid_d  = 1'b1;
      retire_op_d     = op_q[head_q];
      retire_vd_d     = vd_q[head_q];
      head_d          = head_q + TAG_ONE;
      if (!vd_shared) begin
        busy_d[vd_q[head_q]] = 1'b0;
      end
    end

    // Accept writes the tail slot; it cannot alias the retiring head because
    // accept requires a non-full table. Applied last so a fresh entry always
    // starts in IS even if a stray update targeted the same slot.
    if (accept) begin
      valid_d[tail_q] = 1'b1;
      op_d[tail_q]    = sb.issue_op;
      vd_d[tail_q]    = sb.issue_vd;
      stage_d[tail_q] = ST_IS;
      tail_d          = tail_q + TAG_ONE;
      busy_d[sb.issue_vd] = 1'b1;
    end

    if (accept && !retire_fire) begin
      count_d = count_q + CNT_ONE;
    end else if (!accept && retire_fire) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      retire_valid_q <= 1'b0;
      retire_op_q    <= '0;
      retire_vd_q    <= '0;
      for (int i = 0; i < NO_OF_SLOTS; i++) begin
        op_q[i]    <= '0;
        vd_q[i]    <= '0;
        stage_q[i] <= ST_IS;
      end
    end else begin
      valid_q        <= valid_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      busy_q         <= busy_d;
      retire_valid_q <= retire_valid_d;
      retire_op_q    <= retire_op_d;
      retire_vd_q    <= retire_vd_d;
      for (int i = 0; i < NO_OF_SLOTS; i++) begin
        op_q[i]    <= op_d[i];
        vd_q[i]    <= vd_d[i];
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign sb.issue_ready  = !full && !hazard;
  assign sb.issue_tag    = tail_q;
  assign sb.hazard       = hazard;
  assign sb.retire_valid = retire_valid_q;
  assign sb.retire_op    = retire_op_q;
  assign sb.retire_vd    = retire_vd_q;
  assign sb.count        = count_q;
  assign sb.full         = full;
  assign sb.empty        = (count_q == '0);

endmodule

// File: tb/tb_v_ist_scoreboard.sv
module tb_v_ist_scoreboard;
  localparam int NO_OF_SLOTS = 8;
  localparam int OP_BITS     = 6;
  localparam int NUM_VREGS   = 32;
  localparam int RW          = 5;
  localparam int W           = OP_BITS + RW;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  v_ist_scoreboard_if #(.NO_OF_SLOTS(NO_OF_SLOTS), .OP_BITS(OP_BITS), .NUM_VREGS(NUM_VREGS)) sb_if ();

  v_ist_scoreboard #(.NO_OF_SLOTS(NO_OF_SLOTS), .OP_BITS(OP_BITS), .NUM_VREGS(NUM_VREGS)) dut (
    .clk  (clk),
    .nrst (nrst),
    .sb   (sb_if.slave)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_got;
  logic [W-1:0] mon_exp;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.issue_valid = 1'b0;
    sb_if.issue_op    = '0;
    sb_if.issue_vd    = '0;
    sb_if.issue_vs1   = '0;
    sb_if.issue_vs2   = '0;
    sb_if.upd_valid   = 1'b0;
    sb_if.upd_tag     = '0;
    sb_if.upd_stage   = '0;
  endtask

  task automatic drive_issue(input int op, input int vd, input int vs1, input int vs2);
    sb_if.issue_valid = 1'b1;
    sb_if.issue_op    = OP_BITS'(op);
    sb_if.issue_vd    = RW'(vd);
    sb_if.issue_vs1   = RW'(vs1);
    sb_if.issue_vs2   = RW'(vs2);
    #1;
  endtask

  task automatic drive_upd(input int tag, input int stage);
    sb_if.upd_valid = 1'b1;
    sb_if.upd_tag   = 3'(tag);
    sb_if.upd_stage = 3'(stage);
  endtask

  task automatic upd(input int tag, input int stage);
    drive_upd(tag, stage);
    step();
    sb_if.upd_valid = 1'b0;
  endtask

  task automatic expect_retire(input int op, input int vd);
    exp_q.push_back({OP_BITS'(op), RW'(vd)});
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 40 && !sb_if.empty; i++) step();
    chk(name, int'(sb_if.empty), 1);
    step();
  endtask

  task automatic do_reset();
    idle();
    nrst = 1'b0;
    step();
    step();
    chk("rst_count", int'(sb_if.count), 0);
    chk("rst_empty", int'(sb_if.empty), 1);
    nrst = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (nrst && sb_if.retire_valid) begin
      mon_got = {sb_if.retire_op, sb_if.retire_vd};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: got op=%0d vd=%0d expected no retire", sb_if.retire_op, sb_if.retire_vd);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL retire_data: got op=%0d vd=%0d expected op=%0d vd=%0d",
                   mon_got[W-1:RW], mon_got[RW-1:0], mon_exp[W-1:RW], mon_exp[RW-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle();
    // Reset state
    nrst = 1'b0;
    step();
    step();
    chk("reset_count", int'(sb_if.count), 0);
    chk("reset_empty", int'(sb_if.empty), 1);
    chk("reset_full", int'(sb_if.full), 0);
    chk("reset_retire_valid", int'(sb_if.retire_valid), 0);
    chk("reset_issue_ready", int'(sb_if.issue_ready), 1);
    nrst = 1'b1;
    step();

    // Fill: vd=1..8 take tags 0..7
    for (int i = 0; i < 8; i++) begin
      drive_issue(16 + i, i + 1, 0, 0);
      chk("fill_tag", int'(sb_if.issue_tag), i);
      chk("fill_ready", int'(sb_if.issue_ready), 1);
      step();
    end
    drive_issue(48, 9, 0, 0);
    chk("fill_full", int'(sb_if.full), 1);
    chk("fill_count", int'(sb_if.count), 8);
    chk("fill_ready_9th", int'(sb_if.issue_ready), 0);
    chk("fill_no_hazard_9th", int'(sb_if.hazard), 0);

    // Wrap + simultaneous accept/retire while vd=9 stays presented
    expect_retire(16, 1);
    drive_upd(0, 4);
    step();                       // tag0 DONE
    expect_retire(17, 2);
    drive_upd(1, 4);
    chk("wrap_ready_full", int'(sb_if.issue_ready), 0);
    step();                       // tag0 retires (no accept: full), tag1 DONE
    sb_if.upd_valid = 1'b0;
    chk("wrap_retire0", int'(sb_if.retire_valid), 1);
    chk("wrap_count7", int'(sb_if.count), 7);
    chk("wrap_ready", int'(sb_if.issue_ready), 1);
    chk("wrap_tag0", int'(sb_if.issue_tag), 0);
    step();                       // accept vd=9 + retire tag1
    chk("wrap_simul_count", int'(sb_if.count), 7);
    chk("wrap_simul_retire_vd", int'(sb_if.retire_vd), 2);
    drive_issue(49, 10, 0, 0);
    chk("wrap_tag1", int'(sb_if.issue_tag), 1);
    step();
    chk("wrap_refull_count", int'(sb_if.count), 8);
    chk("wrap_refull_full", int'(sb_if.full), 1);
    idle();
    for (int t = 2; t < 8; t++) begin
      expect_retire(16 + t, t + 1);
      upd(t, 4);
    end
    expect_retire(48, 9);
    upd(0, 4);
    expect_retire(49, 10);
    upd(1, 4);
    wait_empty("wrap_drain_empty");

    // RAW hazard
    do_reset();
    drive_issue(33, 3, 0, 0);
    chk("raw_tag0", int'(sb_if.issue_tag), 0);
    step();
    drive_issue(34, 4, 3, 0);
    chk("raw_hazard", int'(sb_if.hazard), 1);
    chk("raw_ready", int'(sb_if.issue_ready), 0);
    expect_retire(33, 3);
    drive_upd(0, 4);
    step();                       // stage DONE, still busy
    sb_if.upd_valid = 1'b0;
    chk("raw_hazard_done", int'(sb_if.hazard), 1);
    chk("raw_no_retire_yet", int'(sb_if.retire_valid), 0);
    step();                       // retire
    chk("raw_retire_valid", int'(sb_if.retire_valid), 1);
    chk("raw_retire_op", int'(sb_if.retire_op), 33);
    chk("raw_retire_vd", int'(sb_if.retire_vd), 3);
    chk("raw_hazard_clear", int'(sb_if.hazard), 0);
    chk("raw_dep_tag", int'(sb_if.issue_tag), 1);
    step();                       // dependent accepted
    chk("raw_dep_count", int'(sb_if.count), 1);
    chk("raw_retire_pulse", int'(sb_if.retire_valid), 0);
    idle();
    expect_retire(34, 4);
    upd(1, 4);
    wait_empty("raw_drain_empty");

    // In-order retire
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_issue(11 + i, 11 + i, 0, 0);
      step();
    end
    idle();
    upd(2, 4);
    expect_retire(11, 11);
    upd(0, 4);
    step();
    step();
    chk("ino_count_after_tag0", int'(sb_if.count), 2);
    expect_retire(12, 12);
    expect_retire(13, 13);
    upd(1, 4);
    chk("ino_no_retire_yet", int'(sb_if.retire_valid), 0);
    step();
    chk("ino_retire1_valid", int'(sb_if.retire_valid), 1);
    chk("ino_retire1_vd", int'(sb_if.retire_vd), 12);
    step();
    chk("ino_retire2_valid", int'(sb_if.retire_valid), 1);
    chk("ino_retire2_vd", int'(sb_if.retire_vd), 13);
    step();
    chk("ino_count0", int'(sb_if.count), 0);

    // Illegal / ignored updates; leave an entry live to exercise mid-op reset
    drive_issue(5, 7, 0, 0);
    step();
    idle();
    do_reset();
    drive_issue(20, 20, 0, 0);
    step();
    drive_issue(21, 20, 0, 0);
    chk("waw_hazard", int'(sb_if.hazard), 1);
    idle();
    upd(0, 2);
    upd(0, 1);
    upd(0, 6);
    upd(3, 4);
    step();
    step();
    chk("illegal_count", int'(sb_if.count), 1);
    chk("illegal_no_retire", int'(sb_if.retire_valid), 0);
    expect_retire(20, 20);
    upd(0, 4);
    wait_empty("illegal_drain_empty");

    step();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
